// File: rtl/gshare_pkg.sv
// gshare_pkg
// Shared types and helpers for the gshare direction predictor.
//   state_e      : INIT (table sweep) / RUN (normal operation)
//   sat_update   : next value of an N-bit saturating counter (N <= 4)
//   make_index   : counter-table index from PC and global history
//   ctr_weak_nt  : weakly-not-taken value for a given counter width
package gshare_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Helpers work on the widest supported counter; callers cast to CTR_WIDTH.
    localparam int CTR_MAX_WIDTH = 4;

    // Largest value whose MSB is still 0, e.g. 2'b01 or 3'b011.
    function automatic logic [CTR_MAX_WIDTH-1:0] ctr_weak_nt(input int width);
        return CTR_MAX_WIDTH'((32'd1 << (width - 1)) - 32'd1);
    endfunction

    function automatic logic [CTR_MAX_WIDTH-1:0] sat_update(
        input logic [CTR_MAX_WIDTH-1:0] ctr,
        input logic                     taken,
        input logic                     jump,
        input int                       width
    );
        logic [CTR_MAX_WIDTH-1:0] ctr_max;
        logic [CTR_MAX_WIDTH-1:0] result;
        ctr_max = CTR_MAX_WIDTH'((32'd1 << width) - 32'd1);
        if (jump) begin
            result = ctr_max;
        end else if (taken) begin
            result = (ctr == ctr_max) ? ctr : ctr + 4'd1;
        end else begin
            result = (ctr == 4'd0) ? ctr : ctr - 4'd1;
        end
        return result;
    endfunction

    // Word-aligned PC bits, optionally hashed with the zero-extended history.
    function automatic logic [31:0] make_index(
        input logic [31:0] pc,
        input logic [31:0] ghr,
        input int          s_index,
        input logic        gshare
    );
        logic [31:0] mask;
        logic [31:0] idx;
        mask = (32'd1 << s_index) - 32'd1;
        idx  = (pc >> 2) & mask;
        if (gshare) begin
            idx = idx ^ (ghr & mask);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gshare_predictor_table.sv
// bht_ctr_table
// Counter storage for the predictor: 2^S_INDEX entries of CTR_WIDTH bits.
//   rd_en/rd_idx -> rd_taken : registered read of the counter MSB, holds
//                              when rd_en=0, write-first on same-cycle write
//   crd_idx -> crd_data      : combinational read for read-modify-write
//   we/wr_idx/wr_data        : single write port
// The array itself is not reset; only the registered read bit is.
module bht_ctr_table
    import gshare_pkg::*;
#(
    parameter int S_INDEX   = 10,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [S_INDEX-1:0]   rd_idx,
    output logic                 rd_taken,
    input  logic [S_INDEX-1:0]   crd_idx,
    output logic [CTR_WIDTH-1:0] crd_data,
    input  logic                 we,
    input  logic [S_INDEX-1:0]   wr_idx,
    input  logic [CTR_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 1 << S_INDEX;

    logic [CTR_WIDTH-1:0] mem [DEPTH];
    logic                 rd_taken_d;
    logic                 rd_taken_q;

    always_comb begin
        rd_taken_d = rd_taken_q;
        if (rd_en) begin
            if (we && (wr_idx == rd_idx)) begin
                rd_taken_d = wr_data[CTR_WIDTH-1];
            end else begin
                rd_taken_d = mem[rd_idx][CTR_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_taken_q <= 1'b0;
        end else begin
            rd_taken_q <= rd_taken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign crd_data = mem[crd_idx];
    assign rd_taken = rd_taken_q;

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor
// Fetch-stage direction predictor: saturating-counter table indexed by PC
// (bimodal) or PC XOR global history (gshare), trained by resolved branches.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   lookup_en, lookup_pc            fetch lookup request
//   pred_valid, pred_taken, pred_ghr  registered prediction + history snapshot
//   upd_*                           resolved branch/jump from EX
//   ready                           table sweep complete
//   stat_branches, stat_mispredicts saturating update statistics
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | sweep writes weakly-not-taken into every entry, I/O ignored
// RUN   | lookups and updates serviced until next reset
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int S_INDEX   = 10,
    parameter int CTR_WIDTH = 2,
    parameter int GHR_WIDTH = 10,
    parameter int GSHARE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lookup_en,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_jump,
    input  logic                 upd_mispredict,
    output logic                 ready,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));
    localparam logic [S_INDEX-1:0]   SWEEP_LAST  = '1;

    state_e               state_d, state_q;
    logic [S_INDEX-1:0]   sweep_d, sweep_q;
    logic [GHR_WIDTH-1:0] ghr_d, ghr_q;
    logic                 pred_valid_d, pred_valid_q;
    logic [GHR_WIDTH-1:0] pred_ghr_d, pred_ghr_q;
    logic [31:0]          stat_br_d, stat_br_q;
    logic [31:0]          stat_mp_d, stat_mp_q;

    logic [S_INDEX-1:0]   lookup_idx;
    logic [S_INDEX-1:0]   upd_idx;
    logic [CTR_WIDTH-1:0] upd_ctr_old;
    logic [CTR_WIDTH-1:0] upd_ctr_new;

    logic                 tbl_rd_en;
    logic                 tbl_we;
    logic [S_INDEX-1:0]   tbl_wr_idx;
    logic [CTR_WIDTH-1:0] tbl_wr_data;
    logic                 tbl_rd_taken;

    // Lookup hashes with the pre-shift history; a same-cycle update only
    // moves the GHR at the clock edge.
    assign lookup_idx  = S_INDEX'(make_index(lookup_pc, 32'(ghr_q), S_INDEX, GSHARE != 0));
    assign upd_idx     = S_INDEX'(make_index(upd_pc, 32'(upd_ghr), S_INDEX, GSHARE != 0));
    assign upd_ctr_new = CTR_WIDTH'(sat_update(4'(upd_ctr_old), upd_taken, upd_jump, CTR_WIDTH));

    bht_ctr_table #(
        .S_INDEX   (S_INDEX),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (tbl_rd_en),
        .rd_idx   (lookup_idx),
        .rd_taken (tbl_rd_taken),
        .crd_idx  (upd_idx),
        .crd_data (upd_ctr_old),
        .we       (tbl_we),
        .wr_idx   (tbl_wr_idx),
        .wr_data  (tbl_wr_data)
    );

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_ghr_d   = pred_ghr_q;
        stat_br_d    = stat_br_q;
        stat_mp_d    = stat_mp_q;
        tbl_rd_en    = 1'b0;
        tbl_we       = 1'b0;
        tbl_wr_idx   = upd_idx;
        tbl_wr_data  = upd_ctr_new;

        case (state_q)
            INIT: begin
                tbl_we      = 1'b1;
                tbl_wr_idx  = sweep_q;
                tbl_wr_data = CTR_WEAK_NT;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                tbl_rd_en    = lookup_en;
                pred_valid_d = lookup_en;
                if (lookup_en) begin
                    pred_ghr_d = ghr_q;
                end
                if (upd_valid) begin
                    tbl_we = 1'b1;
                    if (!upd_jump) begin
                        ghr_d = (ghr_q << 1) | GHR_WIDTH'(upd_taken);
                    end
                    if (stat_br_q != 32'hFFFF_FFFF) begin
                        stat_br_d = stat_br_q + 32'd1;
                    end
                    if (upd_mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
                        stat_mp_d = stat_mp_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_ghr_q   <= '0;
            stat_br_q    <= '0;
            stat_mp_q    <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_ghr_q   <= pred_ghr_d;
            stat_br_q    <= stat_br_d;
            stat_mp_q    <= stat_mp_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = tbl_rd_taken;
    assign pred_ghr         = pred_ghr_q;
    assign ready            = (state_q == RUN);
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal instance (4-bit index) and a gshare
// instance (6-bit index) share clock and reset. Lookups push expected
// predictions into per-instance queues; negedge monitors pop and compare.
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        b_lookup_en, b_pred_valid, b_pred_taken, b_upd_valid;
    logic [31:0] b_lookup_pc, b_upd_pc, b_stat_branches, b_stat_mispredicts;
    logic [3:0]  b_pred_ghr, b_upd_ghr;
    logic        b_upd_taken, b_upd_jump, b_upd_mispredict, b_ready;

    logic        g_lookup_en, g_pred_valid, g_pred_taken, g_upd_valid;
    logic [31:0] g_lookup_pc, g_upd_pc, g_stat_branches, g_stat_mispredicts;
    logic [5:0]  g_pred_ghr, g_upd_ghr;
    logic        g_upd_taken, g_upd_jump, g_upd_mispredict, g_ready;

    gshare_predictor #(.S_INDEX(4), .CTR_WIDTH(2), .GHR_WIDTH(4), .GSHARE(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(b_lookup_en), .lookup_pc(b_lookup_pc),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_ghr(b_pred_ghr),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_ghr(b_upd_ghr),
        .upd_taken(b_upd_taken), .upd_jump(b_upd_jump), .upd_mispredict(b_upd_mispredict),
        .ready(b_ready), .stat_branches(b_stat_branches), .stat_mispredicts(b_stat_mispredicts)
    );

    gshare_predictor #(.S_INDEX(6), .CTR_WIDTH(2), .GHR_WIDTH(6), .GSHARE(1)) dut_g (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(g_lookup_en), .lookup_pc(g_lookup_pc),
        .pred_valid(g_pred_valid), .pred_taken(g_pred_taken), .pred_ghr(g_pred_ghr),
        .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_ghr(g_upd_ghr),
        .upd_taken(g_upd_taken), .upd_jump(g_upd_jump), .upd_mispredict(g_upd_mispredict),
        .ready(g_ready), .stat_branches(g_stat_branches), .stat_mispredicts(g_stat_mispredicts)
    );

    typedef struct {
        logic       taken;
        logic [7:0] ghr;
    } exp_t;

    exp_t q_b[$];
    exp_t q_g[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_pred_valid === 1'b1) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL b_pred_unexpected: pred_valid with nothing expected at %0t", $time);
            end else begin
                e = q_b.pop_front();
                if (b_pred_taken !== e.taken || {4'b0, b_pred_ghr} !== e.ghr) begin
                    n_err++;
                    $display("FAIL b_pred: taken=%0b ghr=%0h, expected taken=%0b ghr=%0h",
                             b_pred_taken, b_pred_ghr, e.taken, e.ghr);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_g
        exp_t e;
        if (g_pred_valid === 1'b1) begin
            n_vec++;
            if (q_g.size() == 0) begin
                n_err++;
                $display("FAIL g_pred_unexpected: pred_valid with nothing expected at %0t", $time);
            end else begin
                e = q_g.pop_front();
                if (g_pred_taken !== e.taken || {2'b0, g_pred_ghr} !== e.ghr) begin
                    n_err++;
                    $display("FAIL g_pred: taken=%0b ghr=%0h, expected taken=%0b ghr=%0h",
                             g_pred_taken, g_pred_ghr, e.taken, e.ghr);
                end
            end
        end
    end

    // One clock of stimulus to one instance; inputs change 1 time unit after posedge.
    task automatic op(input bit to_g, input bit lk, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input logic [7:0] ughr,
                      input bit ut, input bit uj, input bit um,
                      input bit et, input logic [7:0] eg);
        exp_t e;
        e.taken = et;
        e.ghr   = eg;
        if (!to_g) begin
            if (lk) q_b.push_back(e);
            b_lookup_en = lk; b_lookup_pc = lpc;
            b_upd_valid = uv; b_upd_pc = upc; b_upd_ghr = ughr[3:0];
            b_upd_taken = ut; b_upd_jump = uj; b_upd_mispredict = um;
        end else begin
            if (lk) q_g.push_back(e);
            g_lookup_en = lk; g_lookup_pc = lpc;
            g_upd_valid = uv; g_upd_pc = upc; g_upd_ghr = ughr[5:0];
            g_upd_taken = ut; g_upd_jump = uj; g_upd_mispredict = um;
        end
        @(posedge clk); #1;
        b_lookup_en = 1'b0; b_upd_valid = 1'b0;
        g_lookup_en = 1'b0; g_upd_valid = 1'b0;
    endtask

    task automatic look(input bit to_g, input logic [31:0] pc, input bit et, input logic [7:0] eg);
        op(to_g, 1'b1, pc, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, et, eg);
    endtask

    task automatic upd(input bit to_g, input logic [31:0] pc, input logic [7:0] gh,
                       input bit t, input bit j, input bit m);
        op(to_g, 1'b0, 32'h0, 1'b1, pc, gh, t, j, m, 1'b0, 8'h0);
    endtask

    task automatic count_b_init(input string name);
        int cnt;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        b_lookup_en = 0; b_lookup_pc = 0; b_upd_valid = 0; b_upd_pc = 0; b_upd_ghr = 0;
        b_upd_taken = 0; b_upd_jump = 0; b_upd_mispredict = 0;
        g_lookup_en = 0; g_lookup_pc = 0; g_upd_valid = 0; g_upd_pc = 0; g_upd_ghr = 0;
        g_upd_taken = 0; g_upd_jump = 0; g_upd_mispredict = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_b_pred_valid", 32'(b_pred_valid), 32'd0);
        chk("rst_b_pred_taken", 32'(b_pred_taken), 32'd0);
        chk("rst_b_stat_br", b_stat_branches, 32'd0);
        chk("rst_g_ready", 32'(g_ready), 32'd0);
        rst_n = 1'b1;

        // Reset part-way through the sweep; it must restart from entry 0.
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("midsweep_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Requests during INIT must be ignored.
        b_lookup_en = 1'b1; b_lookup_pc = 32'h40;
        b_upd_valid = 1'b1; b_upd_pc = 32'h40; b_upd_taken = 1'b1; b_upd_mispredict = 1'b1;
        count_b_init("b_init_cycles");
        b_lookup_en = 1'b0; b_upd_valid = 1'b0; b_upd_mispredict = 1'b0;
        chk("b_init_stat_br", b_stat_branches, 32'd0);
        chk("b_init_stat_mp", b_stat_mispredicts, 32'd0);

        // Bimodal: entry 0 (PC 0x40) trained up and back down.
        look(1'b0, 32'h3C, 1'b0, 8'h0);
        look(1'b0, 32'h0,  1'b0, 8'h0);
        upd (1'b0, 32'h40, 8'hA, 1'b1, 1'b0, 1'b1);   // 01->10, ghr 1
        look(1'b0, 32'h40, 1'b1, 8'h1);
        upd (1'b0, 32'h40, 8'hA, 1'b1, 1'b0, 1'b0);   // 11, ghr 3
        upd (1'b0, 32'h40, 8'hA, 1'b1, 1'b0, 1'b0);   // 11 sat, ghr 7
        look(1'b0, 32'h40, 1'b1, 8'h7);
        upd (1'b0, 32'h40, 8'hA, 1'b0, 1'b0, 1'b1);   // 10, ghr E
        chk("b_hold_valid", 32'(b_pred_valid), 32'd0);
        chk("b_hold_taken", 32'(b_pred_taken), 32'd1);
        upd (1'b0, 32'h40, 8'hA, 1'b0, 1'b0, 1'b0);   // 01, ghr C
        look(1'b0, 32'h40, 1'b0, 8'hC);
        chk("b_stat_br", b_stat_branches, 32'd5);
        chk("b_stat_mp", b_stat_mispredicts, 32'd2);
        upd (1'b0, 32'h44, 8'h0, 1'b1, 1'b0, 1'b0);   // entry 1 -> 10, ghr 9
        look(1'b0, 32'h44, 1'b1, 8'h9);

        cnt = 0;
        while (g_ready !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("g_ready", 32'(g_ready), 32'd1);

        // Gshare: train index 0x40>>2 ^ 3 = 0x13, then flush history to 0.
        upd(1'b1, 32'h40, 8'h3, 1'b1, 1'b0, 1'b0);    // 0x13 -> 10, ghr 01
        upd(1'b1, 32'h40, 8'h3, 1'b1, 1'b0, 1'b0);    // 0x13 -> 11, ghr 03
        for (int i = 0; i < 6; i++) begin
            upd(1'b1, 32'h100, 8'h0, 1'b0, 1'b0, 1'b0); // entry 0 -> 00, ghr shifts to 0
        end
        look(1'b1, 32'h4C, 1'b1, 8'h0);               // index 0x13
        look(1'b1, 32'h40, 1'b0, 8'h0);               // index 0x10
        chk("g_stat_br_8", g_stat_branches, 32'd8);
        upd (1'b1, 32'h100, 8'h0, 1'b1, 1'b1, 1'b1);  // jump: 00 -> 11, ghr unchanged
        chk("g_jump_stat_br", g_stat_branches, 32'd9);
        chk("g_jump_stat_mp", g_stat_mispredicts, 32'd1);
        look(1'b1, 32'h100, 1'b1, 8'h0);
        upd (1'b1, 32'h100, 8'h0, 1'b0, 1'b0, 1'b0);  // 11 -> 10
        look(1'b1, 32'h100, 1'b1, 8'h0);
        // Collision on index 5: bypass gives new value, lookup sees old GHR.
        op(1'b1, 1'b1, 32'h14, 1'b1, 32'h14, 8'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0);
        look(1'b1, 32'h14, 1'b0, 8'h1);               // index 5^1 = 4, still 01
        chk("g_stat_br", g_stat_branches, 32'd11);
        chk("g_stat_mp", g_stat_mispredicts, 32'd2);

        // Async reset in RUN, between clock edges.
        @(posedge clk); #1;
        chk("b_pre_reset_taken", 32'(b_pred_taken), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_b_pred_taken", 32'(b_pred_taken), 32'd0);
        chk("arst_b_pred_ghr", 32'(b_pred_ghr), 32'd0);
        chk("arst_b_ready", 32'(b_ready), 32'd0);
        chk("arst_b_stat_br", b_stat_branches, 32'd0);
        chk("arst_b_stat_mp", b_stat_mispredicts, 32'd0);
        chk("arst_g_stat_br", g_stat_branches, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_b_init("b_reinit_cycles");
        look(1'b0, 32'h44, 1'b0, 8'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        chk("g_queue_drained", 32'(q_g.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised direction predictor for the fetch stage, successor to the bimodal 2-bit BHT. Indexes a table of N-bit saturating counters with either PC bits alone (bimodal) or PC XOR global history (gshare). Resolved branches from EX update the table and the history register. Reset runs a hardware sweep of the table, and the block exposes mispredict statistics.

Parameters:
S_INDEX, 10, log2 of counter-table entries.
CTR_WIDTH, 2, counter width in bits (2..4).
GHR_WIDTH, 10, global history length; must satisfy GHR_WIDTH <= S_INDEX.
GSHARE, 1, 1 = index is PC XOR GHR; 0 = bimodal, GHR not used for indexing.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lookup_en  in  1  fetch lookup request this cycle
lookup_pc  in  32  fetch PC
pred_valid  out  1  prediction registered from previous cycle's lookup
pred_taken  out  1  predicted direction, equal to counter MSB
pred_ghr  out  GHR_WIDTH  GHR snapshot used for the lookup; pipeline carries it to EX
upd_valid  in  1  resolved control-flow instruction in EX
upd_pc  in  32  PC of resolved instruction
upd_ghr  in  GHR_WIDTH  pred_ghr carried with that instruction
upd_taken  in  1  actual outcome (br_en)
upd_jump  in  1  unconditional jump
upd_mispredict  in  1  pipeline flushed for this instruction
ready  out  1  table initialised; predictions are meaningful
stat_branches  out  32  count of updates accepted
stat_mispredicts  out  32  count of accepted updates with upd_mispredict=1

Behaviour:
- Index: idx(pc,g) = pc[S_INDEX+1:2] XOR zero-extended g when GSHARE=1; pc[S_INDEX+1:2] when GSHARE=0.
- Lookup latency is 1 cycle. lookup_en at cycle t gives pred_valid=1 at t+1 with counter value ctr[idx(lookup_pc, ghr at t)]. pred_ghr is ghr at t.
- No lookup (lookup_en=0): pred_valid=0 next cycle, and pred_taken holds its last value.
- Update is a read-modify-write in one cycle. It reads ctr[idx(upd_pc, upd_ghr)] combinationally and writes the new value at the clock edge.
  - upd_jump=1: counter set to max (all ones).
  - Otherwise the counter saturates: +1 if taken, -1 if not taken, clamped to 0 and 2^CTR_WIDTH-1.
- GHR update: on an accepted update with upd_jump=0, ghr <= {ghr[GHR_WIDTH-2:0], upd_taken}. Jumps do not shift history. The GHR is non-speculative; there is no recovery path.
- Same-cycle lookup and update to the same index: the lookup returns the newly written value (write-first bypass).
- Same-cycle lookup and GHR shift: the lookup uses the pre-shift GHR.
- Statistics: stat_branches increments on every accepted update. stat_mispredicts increments on an accepted update with upd_mispredict=1. Both saturate at 0xFFFF_FFFF.
- FSM states: INIT and RUN.
  - INIT: an S_INDEX-bit sweep pointer writes the weakly-not-taken value 2^(CTR_WIDTH-1)-1 (01 for 2-bit) to one entry per cycle, from 0 up to 2^S_INDEX-1.
  - INIT -> RUN after the last entry is written, so INIT lasts exactly 2^S_INDEX cycles.
  - In INIT: ready=0, pred_valid=0, pred_taken=0, and updates and lookups are ignored (not counted, GHR unchanged).
  - In RUN: ready=1. RUN persists until reset.
- Reset (asynchronous, including mid-sweep or mid-operation):
  - state=INIT, sweep pointer=0, ghr=0.
  - pred_valid=0, pred_taken=0, pred_ghr=0, ready=0, both stats=0.
  - The sweep restarts from entry 0.
- Counter table is a logic-style array with no reset; it is initialised only by the sweep.

Decomposition:
- Package gshare_pkg:
  - state enum {INIT, RUN}.
  - Function sat_update(ctr, taken, jump).
  - Function make_index(pc, ghr).
  - Constant CTR_WEAK_NT.
- Sub-module bht_ctr_table: parametrised array with one registered read port (with write-first bypass), one combinational read port, and one write port. Top-level muxes the write port between the sweep and the update.

Test Plan:
- Reset then idle (S_INDEX=4): ready=0 for exactly 16 cycles, then 1. Lookup of any PC in the next cycle gives pred_taken=0. Reading any entry directly gives 01.
- Bimodal (GSHARE=0): three taken updates to PC 0x40. Counter goes 01->10->11->11. Lookup after the 1st update gives taken=1. Two not-taken updates then give 01, so taken=0.
- Gshare aliasing: upd_pc 0x40 with upd_ghr 0x3 trains index 0x10^0x3=0x13 to 11. Lookup PC 0x4C with ghr=0 (index 0x13) predicts taken; lookup PC 0x40 with ghr=0 predicts not taken.
- Collision: update and lookup target the same index in the same cycle, update taken from 01. pred_taken=1 next cycle (bypass). GHR shifts after the lookup, and pred_ghr shows the old value.
- Jump: upd_jump=1 on an entry holding 00 sets it to 11. GHR unchanged. stat_branches +1.
- Async reset: assert rst_n=0 mid-sweep, and separately in RUN with stats at 5/2. Outputs go to zero immediately, without waiting for a clock edge. The sweep restarts and ready stays 0 for the full 2^S_INDEX cycles.
